// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Interface : mem_port_arbiter_if
// Brief     : Bundles the upstream per-requester port buses and the single
//             downstream memory-controller port seen by mem_port_arbiter.
//             Slice i of every packed per-requester bus is [i*W +: W].
// Revision  : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if #(
  parameter int REQ_CNT = 2,
  parameter int ADDR_W  = 32
);

  // Upstream side, one slice per requester
  logic [REQ_CNT*2-1:0]      req_rw_flag;
  logic [REQ_CNT*ADDR_W-1:0] req_addr;
  logic [REQ_CNT*ADDR_W-1:0] req_write_data;
  logic [REQ_CNT*4-1:0]      req_write_mask;
  logic [REQ_CNT*ADDR_W-1:0] req_read_data;
  logic [REQ_CNT-1:0]        req_busy;
  logic [REQ_CNT-1:0]        req_done;

  // Downstream memory-controller port
  logic [1:0]                mem_rw_flag;
  logic [ADDR_W-1:0]         mem_addr;
  logic [ADDR_W-1:0]         mem_write_data;
  logic [3:0]                mem_write_mask;
  logic [ADDR_W-1:0]         mem_read_data;
  logic                      mem_busy;
  logic                      mem_done;

  // Arbiter view: consumes requests and memory responses
  modport slave (
    input  req_rw_flag, req_addr, req_write_data, req_write_mask,
    input  mem_read_data, mem_busy, mem_done,
    output req_read_data, req_busy, req_done,
    output mem_rw_flag, mem_addr, mem_write_data, mem_write_mask
  );

  // Environment view: the requesters plus the memory controller
  modport master (
    output req_rw_flag, req_addr, req_write_data, req_write_mask,
    output mem_read_data, mem_busy, mem_done,
    input  req_read_data, req_busy, req_done,
    input  mem_rw_flag, mem_addr, mem_write_data, mem_write_mask
  );

endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Round-robin arbiter sharing one memory-controller port between
//            REQ_CNT requesters. The port is locked to the winner from issue
//            until the memory reports completion. All outputs registered.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int REQ_CNT = 2,
  parameter int ADDR_W  = 32
) (
  input  logic              CLK,
  input  logic              RST,
  mem_port_arbiter_if.slave bus
);

  localparam int GRANT_W = (REQ_CNT > 1) ? $clog2(REQ_CNT) : 1;
  // Last winner after reset is the highest index so requester 0 wins first
  localparam logic [GRANT_W-1:0] C_LAST_RST  = GRANT_W'(REQ_CNT - 1);
  localparam logic [1:0]         C_CMD_NONE  = 2'b00;
  localparam logic [1:0]         C_CMD_READ  = 2'b01;
  localparam logic [1:0]         C_CMD_WRITE = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;

  logic [GRANT_W-1:0]        r_grant;
  logic [GRANT_W-1:0]        r_last;
  logic                      r_cmd_read;

  logic [1:0]                r_mem_rw_flag;
  logic [ADDR_W-1:0]         r_mem_addr;
  logic [ADDR_W-1:0]         r_mem_write_data;
  logic [3:0]                r_mem_write_mask;

  logic [REQ_CNT*ADDR_W-1:0] r_req_read_data;
  logic [REQ_CNT-1:0]        r_req_busy;
  logic [REQ_CNT-1:0]        r_req_done;

  logic [REQ_CNT-1:0]        w_cand;
  logic                      w_any;
  logic [GRANT_W-1:0]        w_winner;
  int                        w_idx;
  logic [GRANT_W-1:0]        w_pos;

  logic [1:0]                w_sel_flag;
  logic [ADDR_W-1:0]         w_sel_addr;
  logic [ADDR_W-1:0]         w_sel_write_data;
  logic [3:0]                w_sel_write_mask;

  logic                      w_grant_now;
  logic                      w_accept;
  logic                      w_complete;

  // A requester competes when it carries a real command and did not just
  // receive done: its flag is still held during the done cycle, so without
  // this exclusion the completed command would be granted a second time.
  for (genvar gi = 0; gi < REQ_CNT; gi++) begin : g_cand
    logic [1:0] w_flag;
    assign w_flag     = bus.req_rw_flag[gi*2 +: 2];
    assign w_cand[gi] = ((w_flag == C_CMD_READ) || (w_flag == C_CMD_WRITE))
                        && !r_req_done[gi];
  end

  // Round-robin search: first candidate starting just after the last winner
  always_comb begin
    w_winner = r_last;
    w_any    = 1'b0;
    w_idx    = 0;
    w_pos    = '0;
    for (int k = 1; k <= REQ_CNT; k++) begin
      w_idx = (int'(r_last) + k) % REQ_CNT;
      w_pos = w_idx[GRANT_W-1:0];
      if (!w_any && w_cand[w_pos]) begin
        w_any    = 1'b1;
        w_winner = w_pos;
      end
    end
  end

  // Route the winner's command fields toward the downstream registers
  always_comb begin
    w_sel_flag       = C_CMD_NONE;
    w_sel_addr       = '0;
    w_sel_write_data = '0;
    w_sel_write_mask = '0;
    for (int i = 0; i < REQ_CNT; i++) begin
      if (w_winner == GRANT_W'(i)) begin
        w_sel_flag       = bus.req_rw_flag[i*2 +: 2];
        w_sel_addr       = bus.req_addr[i*ADDR_W +: ADDR_W];
        w_sel_write_data = bus.req_write_data[i*ADDR_W +: ADDR_W];
        w_sel_write_mask = bus.req_write_mask[i*4 +: 4];
      end
    end
  end

  // Next-state logic plus the per-state events driving the datapath
  always_comb begin
    w_state_nxt = r_state;
    w_grant_now = 1'b0;
    w_accept    = 1'b0;
    w_complete  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_grant_now = 1'b1;
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // The command stays on the bus for as long as memory reports busy
        if (!bus.mem_busy) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (bus.mem_done) begin
          w_complete  = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register; reset abandons any in-flight transaction
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Remember who owns the port and the round-robin pointer
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_grant    <= '0;
      r_last     <= C_LAST_RST;
      r_cmd_read <= 1'b0;
    end else if (w_grant_now) begin
      r_grant    <= w_winner;
      r_last     <= w_winner;
      r_cmd_read <= (w_sel_flag == C_CMD_READ);
    end
  end

  // Downstream command registers: loaded on grant, flag cleared on accept
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_mem_rw_flag    <= C_CMD_NONE;
      r_mem_addr       <= '0;
      r_mem_write_data <= '0;
      r_mem_write_mask <= '0;
    end else if (w_grant_now) begin
      r_mem_rw_flag    <= w_sel_flag;
      r_mem_addr       <= w_sel_addr;
      r_mem_write_data <= w_sel_write_data;
      r_mem_write_mask <= w_sel_write_mask;
    end else if (w_accept) begin
      r_mem_rw_flag    <= C_CMD_NONE;
    end
  end

  // Busy follows the registered state; done is a single-cycle pulse
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_req_busy <= '0;
      r_req_done <= '0;
    end else begin
      r_req_busy <= {REQ_CNT{w_state_nxt != ST_IDLE}};
      r_req_done <= '0;
      if (w_complete) begin
        for (int i = 0; i < REQ_CNT; i++) begin
          if (r_grant == GRANT_W'(i)) begin
            r_req_done[i] <= 1'b1;
          end
        end
      end
    end
  end

  // Read data lands only in the owner's slice and only for reads
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_req_read_data <= '0;
    end else if (w_complete && r_cmd_read) begin
      for (int i = 0; i < REQ_CNT; i++) begin
        if (r_grant == GRANT_W'(i)) begin
          r_req_read_data[i*ADDR_W +: ADDR_W] <= bus.mem_read_data;
        end
      end
    end
  end

  assign bus.req_read_data  = r_req_read_data;
  assign bus.req_busy       = r_req_busy;
  assign bus.req_done       = r_req_done;
  assign bus.mem_rw_flag    = r_mem_rw_flag;
  assign bus.mem_addr       = r_mem_addr;
  assign bus.mem_write_data = r_mem_write_data;
  assign bus.mem_write_mask = r_mem_write_mask;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Brief    : Directed self-checking bench for mem_port_arbiter. The bench
//            plays both requesters and the memory controller.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  localparam int REQ_CNT = 2;
  localparam int ADDR_W  = 32;

  logic CLK = 1'b0;
  logic RST;

  always #5 CLK = ~CLK;

  mem_port_arbiter_if #(.REQ_CNT(REQ_CNT), .ADDR_W(ADDR_W)) bus ();

  mem_port_arbiter #(.REQ_CNT(REQ_CNT), .ADDR_W(ADDR_W)) u_dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h, expected %0h", tag, act, exp);
    end
  endtask

  // Advance one cycle and sample just after the active edge
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_req(input int idx, input logic [1:0] flag, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] mask);
    bus.req_rw_flag[idx*2 +: 2]     = flag;
    bus.req_addr[idx*32 +: 32]      = addr;
    bus.req_write_data[idx*32 +: 32] = wdata;
    bus.req_write_mask[idx*4 +: 4]  = mask;
  endtask

  // Wait for the issued command, optionally stall it, then complete it after
  // lat cycles in WAIT. Returns in the cycle where req_done should be high.
  task automatic do_txn(input string tag, input logic [1:0] exp_flag, input logic [31:0] exp_addr,
                        input int busy_cyc, input int lat, input logic [31:0] rdata);
    int waited = 0;
    while (bus.mem_rw_flag == 2'b00 && waited < 8) begin
      tick();
      waited++;
    end
    check({tag, " flag"}, bus.mem_rw_flag, exp_flag);
    if (bus.mem_rw_flag == 2'b00) return;
    check({tag, " latency"}, waited, 1);
    check({tag, " addr"}, bus.mem_addr, exp_addr);
    bus.mem_busy = (busy_cyc > 0);
    for (int b = 0; b < busy_cyc; b++) begin
      // A stray done while the command is still stalled must be ignored
      bus.mem_done = (b == 0);
      tick();
      bus.mem_done = 1'b0;
      if (b == busy_cyc - 1) bus.mem_busy = 1'b0;
      check({tag, " stall flag"}, bus.mem_rw_flag, exp_flag);
      check({tag, " stall done"}, bus.req_done, 2'b00);
    end
    tick();
    check({tag, " accepted flag"}, bus.mem_rw_flag, 2'b00);
    check({tag, " busy"}, bus.req_busy, 2'b11);
    repeat (lat - 1) tick();
    bus.mem_done      = 1'b1;
    bus.mem_read_data = rdata;
    tick();
    bus.mem_done      = 1'b0;
    bus.mem_read_data = '0;
  endtask

  logic [31:0] cont_addr [4] = '{32'h300, 32'h400, 32'h300, 32'h400};
  logic [1:0]  cont_done [4] = '{2'b01, 2'b10, 2'b01, 2'b10};

  initial begin
    RST                = 1'b1;
    bus.req_rw_flag    = '0;
    bus.req_addr       = '0;
    bus.req_write_data = '0;
    bus.req_write_mask = '0;
    bus.mem_busy       = 1'b0;
    bus.mem_done       = 1'b0;
    bus.mem_read_data  = '0;
    tick();
    tick();
    check("rst busy", bus.req_busy, 2'b00);
    check("rst done", bus.req_done, 2'b00);
    check("rst mem flag", bus.mem_rw_flag, 2'b00);
    check("rst mem addr", bus.mem_addr, 32'h0);
    check("rst mem wdata", bus.mem_write_data, 32'h0);
    check("rst mem mask", bus.mem_write_mask, 4'h0);
    check("rst rdata", bus.req_read_data, 64'h0);
    RST = 1'b0;
    tick();

    // Single read from requester 0
    set_req(0, 2'b01, 32'h100, 32'h0, 4'h0);
    do_txn("rd0", 2'b01, 32'h100, 0, 3, 32'hDEADBEEF);
    check("rd0 done", bus.req_done, 2'b01);
    check("rd0 rdata0", bus.req_read_data[31:0], 32'hDEADBEEF);
    check("rd0 rdata1", bus.req_read_data[63:32], 32'h0);
    check("rd0 idle", bus.req_busy, 2'b00);
    tick();
    check("rd0 pulse width", bus.req_done, 2'b00);
    check("rd0 no regrant", bus.mem_rw_flag, 2'b00);
    set_req(0, 2'b00, 32'h0, 32'h0, 4'h0);
    tick();
    check("rd0 quiet", bus.mem_rw_flag, 2'b00);

    // Masked write from requester 1
    set_req(1, 2'b10, 32'h204, 32'h11223344, 4'b0011);
    do_txn("wr1", 2'b10, 32'h204, 0, 2, 32'hCAFEF00D);
    check("wr1 wdata", bus.mem_write_data, 32'h11223344);
    check("wr1 mask", bus.mem_write_mask, 4'b0011);
    check("wr1 done", bus.req_done, 2'b10);
    check("wr1 rdata1", bus.req_read_data[63:32], 32'h0);
    check("wr1 rdata0", bus.req_read_data[31:0], 32'hDEADBEEF);
    tick();
    set_req(1, 2'b00, 32'h0, 32'h0, 4'h0);
    tick();
    check("wr1 quiet", bus.mem_rw_flag, 2'b00);

    // Contention: both read continuously, grants must alternate 0,1,0,1
    set_req(0, 2'b01, 32'h300, 32'h0, 4'h0);
    set_req(1, 2'b01, 32'h400, 32'h0, 4'h0);
    for (int k = 0; k < 4; k++) begin
      do_txn($sformatf("cont%0d", k), 2'b01, cont_addr[k], 0, 1, 32'hA0A00000 + 32'(k));
      check($sformatf("cont%0d done", k), bus.req_done, cont_done[k]);
      check($sformatf("cont%0d rdata", k),
            (k % 2 == 0) ? bus.req_read_data[31:0] : bus.req_read_data[63:32],
            32'hA0A00000 + 32'(k));
    end
    set_req(0, 2'b00, 32'h0, 32'h0, 4'h0);
    set_req(1, 2'b00, 32'h0, 32'h0, 4'h0);
    tick();
    check("cont quiet", bus.mem_rw_flag, 2'b00);

    // Busy stall: command held for 6 cycles, one done
    set_req(0, 2'b01, 32'h500, 32'h0, 4'h0);
    do_txn("stall", 2'b01, 32'h500, 5, 2, 32'h55AA55AA);
    check("stall done", bus.req_done, 2'b01);
    check("stall rdata0", bus.req_read_data[31:0], 32'h55AA55AA);
    tick();
    check("stall single done", bus.req_done, 2'b00);
    check("stall no regrant", bus.mem_rw_flag, 2'b00);
    set_req(0, 2'b00, 32'h0, 32'h0, 4'h0);
    tick();

    // Re-request: requester 0 replaces its read the cycle after done
    set_req(0, 2'b01, 32'h100, 32'h0, 4'h0);
    do_txn("rr_a", 2'b01, 32'h100, 0, 1, 32'h12345678);
    check("rr_a done", bus.req_done, 2'b01);
    tick();
    check("rr no dup grant", bus.mem_rw_flag, 2'b00);
    set_req(0, 2'b01, 32'h108, 32'h0, 4'h0);
    do_txn("rr_b", 2'b01, 32'h108, 0, 1, 32'h87654321);
    check("rr_b done", bus.req_done, 2'b01);
    check("rr_b rdata0", bus.req_read_data[31:0], 32'h87654321);
    tick();
    set_req(0, 2'b00, 32'h0, 32'h0, 4'h0);
    tick();

    // Reset while WAITing, memory completes after reset
    set_req(1, 2'b01, 32'h600, 32'h0, 4'h0);
    tick();
    check("mid issue flag", bus.mem_rw_flag, 2'b01);
    tick();
    check("mid wait busy", bus.req_busy, 2'b11);
    set_req(1, 2'b00, 32'h0, 32'h0, 4'h0);
    RST = 1'b1;
    tick();
    check("mid rst busy", bus.req_busy, 2'b00);
    check("mid rst flag", bus.mem_rw_flag, 2'b00);
    check("mid rst addr", bus.mem_addr, 32'h0);
    check("mid rst rdata", bus.req_read_data, 64'h0);
    RST               = 1'b0;
    bus.mem_done      = 1'b1;
    bus.mem_read_data = 32'hBAD0BAD0;
    tick();
    bus.mem_done      = 1'b0;
    bus.mem_read_data = '0;
    check("post rst done", bus.req_done, 2'b00);
    check("post rst rdata", bus.req_read_data, 64'h0);
    check("post rst busy", bus.req_busy, 2'b00);
    tick();
    check("post rst done2", bus.req_done, 2'b00);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one memory_controller port between REQ_CNT requesters inside cpu_core (default: instruction fetch = requester 0, load/store = requester 1).
- Upstream, each requester sees the same port protocol as MEM_rw_flag / MEM_addr / MEM_read_data / MEM_write_data / MEM_write_mask / MEM_busy / MEM_done.
- Downstream, the block drives a single memory port.
- Arbitration is round-robin. The port is locked to the winner from issue until completion.

Parameters:
- REQ_CNT, 2, number of requesters (≥2)
- ADDR_W, 32, address and data width

Ports:
- CLK  in  1  system clock
- RST  in  1  synchronous reset, active-high
- req_rw_flag  in  REQ_CNT*2  per requester, 2'b01 = read, 2'b10 = write, 2'b00 / 2'b11 = no request
- req_addr  in  REQ_CNT*ADDR_W  per-requester byte address
- req_write_data  in  REQ_CNT*ADDR_W  per-requester store data
- req_write_mask  in  REQ_CNT*4  per-requester byte enables
- req_read_data  out  REQ_CNT*ADDR_W  per-requester returned read data
- req_busy  out  REQ_CNT  per requester, 1 = port not in IDLE
- req_done  out  REQ_CNT  one-cycle completion pulse per requester
- mem_rw_flag  out  2  downstream command
- mem_addr  out  ADDR_W  downstream address
- mem_write_data  out  ADDR_W  downstream store data
- mem_write_mask  out  4  downstream byte enables
- mem_read_data  in  ADDR_W  downstream read data, valid with mem_done
- mem_busy  in  1  downstream cannot accept a command
- mem_done  in  1  downstream completion pulse

Behaviour:
- All outputs are registered. Slice i of each packed bus is bits [i*W +: W].
- Reset: state = IDLE, grant = 0, last = REQ_CNT-1 (requester 0 wins first).
  - All outputs are 0, including req_read_data.
  - Reset mid-transaction abandons the transaction. No done is issued.
- States:
  - IDLE:
    - Candidates are requesters with flag 01 or 10, excluding the requester that received done in this same cycle.
    - If no candidate: stay in IDLE.
    - Otherwise: winner = first candidate searching last+1, last+2, … modulo REQ_CNT.
    - Latch grant = winner and last = winner. Latch the winner's flag, addr, data and mask into the mem_* registers. Go to ISSUE.
  - ISSUE:
    - mem_rw_flag holds the latched command.
    - If mem_busy = 0 at the edge, the command is accepted: clear mem_rw_flag to 00 and go to WAIT.
    - If mem_busy = 1, hold the command and stay in ISSUE indefinitely.
  - WAIT:
    - mem_rw_flag = 00.
    - On mem_done = 1:
      - Pulse req_done[grant] for exactly one cycle.
      - If the command was a read, load req_read_data[grant] from mem_read_data. Writes leave req_read_data unchanged.
      - Go to IDLE.
- mem_done in IDLE or ISSUE is ignored.
- req_read_data[i] holds its value until the next read completion for requester i.
- req_busy[i] = 1 for all i whenever state ≠ IDLE, registered with the state.
- Requester contract:
  - Hold flag, addr, data and mask stable from assertion until done.
  - Drop or replace the request in the cycle after done.
  - Inputs are sampled only in IDLE. Changes made while busy do not affect the in-flight command.
- Exclusion of the just-completed requester in the done cycle prevents a stale re-grant. The next transaction from that requester can win no earlier than the cycle after done.
- Latency: request visible in IDLE at cycle 0 → mem_rw_flag at cycle 1 → accepted at end of cycle 1 if not busy. mem_done at cycle n → req_done at cycle n+1. The minimum round-trip adds 2 cycles over the memory latency.
- Fairness: each requester waits at most REQ_CNT-1 foreign transactions.

Test Plan:
- Single read: req 0 reads addr 0x100; memory returns 0xDEADBEEF with done 3 cycles after accept → mem_rw_flag=01 and mem_addr=0x100 for exactly one cycle; req_done[0] pulses once; req_read_data[0]=0xDEADBEEF; req_read_data[1] stays 0.
- Write with mask: req 1 writes 0x11223344 to 0x204 with mask 4'b0011 → downstream sees flag=10, addr=0x204, data=0x11223344, mask=0011; req_done[1] pulses; req_read_data[1] unchanged.
- Contention: both requesters assert reads continuously from reset → grants alternate 0,1,0,1; no requester is granted twice in a row while the other waits.
- Busy stall: mem_busy held high for 5 cycles during ISSUE → mem_rw_flag stays 01 for 6 cycles, then 00; exactly one done results.
- Re-request: req 0 drops its flag after done and re-asserts a read of 0x108 the next cycle, req 1 idle → second grant goes to 0 with addr 0x108; no duplicate grant of 0x100.
- Reset mid-operation: RST asserted in WAIT, then mem_done arrives after reset → all outputs 0; state IDLE; no req_done pulse.
